// File: rtl/key_event_decoder_if.sv
// Key level inputs and decoded one-cycle event pulses of key_event_decoder.
// The master drives the debounced key levels; the slave drives the event pulses.
interface key_event_decoder_if;
  logic left_flag;
  logic right_flag;
  logic left_press;
  logic right_press;
  logic left_release;
  logic right_release;
  logic left_long;
  logic right_long;
  logic left_rpt;
  logic right_rpt;
  logic both_press;

  modport master (
    output left_flag, right_flag,
    input  left_press, right_press, left_release, right_release,
    input  left_long, right_long, left_rpt, right_rpt, both_press
  );

  modport slave (
    input  left_flag, right_flag,
    output left_press, right_press, left_release, right_release,
    output left_long, right_long, left_rpt, right_rpt, both_press
  );
endinterface

// File: rtl/key_event_decoder.sv
// Two-key event decoder: press/release/long/auto-repeat pulses per key plus a
// two-key combo pulse; a combo locks both keys out of long/repeat until release.
module key_event_fsm #(
  parameter logic [31:0] LONG_CNT   = 32'd50_000_000,
  parameter logic [31:0] REPEAT_CNT = 32'd10_000_000
) (
  input  logic clk_50m,
  input  logic rst_n,
  input  logic flag_i,
  input  logic combo_rise_i,
  output logic press_o,
  output logic release_o,
  output logic long_o,
  output logic rpt_o
);
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HELD = 2'd1,
    ST_LONG = 2'd2,
    ST_LOCK = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        prev_q;
  logic        press_q, press_d;
  logic        release_q, release_d;
  logic        long_q, long_d;
  logic        rpt_q, rpt_d;
  logic        rise_s, fall_s;

  assign rise_s = flag_i & ~prev_q;
  assign fall_s = ~flag_i & prev_q;

  // State, hold counter, edge history and registered pulses
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 32'd0;
      prev_q    <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      rpt_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      prev_q    <= flag_i;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      rpt_q     <= rpt_d;
    end
  end

  // Next state and pulses; release beats combo, combo beats long/repeat
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    rpt_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rise_s) begin
          press_d = 1'b1;
          cnt_d   = 32'd0;
          state_d = combo_rise_i ? ST_LOCK : ST_HELD;
        end else begin
          cnt_d   = 32'd0;
          state_d = ST_IDLE;
        end
      end
      ST_HELD: begin
        if (fall_s) begin
          release_d = 1'b1;
          cnt_d     = 32'd0;
          state_d   = ST_IDLE;
        end else if (combo_rise_i) begin
          cnt_d   = 32'd0;
          state_d = ST_LOCK;
        end else if (cnt_q == LONG_CNT - 32'd1) begin
          long_d  = 1'b1;
          cnt_d   = 32'd0;
          state_d = ST_LONG;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_LONG: begin
        if (fall_s) begin
          release_d = 1'b1;
          cnt_d     = 32'd0;
          state_d   = ST_IDLE;
        end else if (combo_rise_i) begin
          cnt_d   = 32'd0;
          state_d = ST_LOCK;
        end else if (cnt_q == REPEAT_CNT - 32'd1) begin
          rpt_d = 1'b1;
          cnt_d = 32'd0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_LOCK: begin
        cnt_d = 32'd0;
        if (fall_s) begin
          release_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          state_d = ST_LOCK;
        end
      end
      default: begin
        cnt_d   = 32'd0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign press_o   = press_q;
  assign release_o = release_q;
  assign long_o    = long_q;
  assign rpt_o     = rpt_q;
endmodule

module key_event_decoder #(
  parameter logic [31:0] LONG_CNT   = 32'd50_000_000,
  parameter logic [31:0] REPEAT_CNT = 32'd10_000_000
) (
  input logic          clk_50m,
  input logic          rst_n,
  key_event_decoder_if.slave key_bus
);
  logic combo_s, combo_rise_s;
  logic combo_prev_q, both_press_q;
  logic l_press_s, l_release_s, l_long_s, l_rpt_s;
  logic r_press_s, r_release_s, r_long_s, r_rpt_s;

  assign combo_s      = key_bus.left_flag & key_bus.right_flag;
  assign combo_rise_s = combo_s & ~combo_prev_q;

  // Combo edge history and registered combo pulse
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      combo_prev_q <= 1'b0;
      both_press_q <= 1'b0;
    end else begin
      combo_prev_q <= combo_s;
      both_press_q <= combo_rise_s;
    end
  end

  key_event_fsm #(.LONG_CNT(LONG_CNT), .REPEAT_CNT(REPEAT_CNT)) u_left (
    .clk_50m      (clk_50m),
    .rst_n        (rst_n),
    .flag_i       (key_bus.left_flag),
    .combo_rise_i (combo_rise_s),
    .press_o      (l_press_s),
    .release_o    (l_release_s),
    .long_o       (l_long_s),
    .rpt_o        (l_rpt_s)
  );

  key_event_fsm #(.LONG_CNT(LONG_CNT), .REPEAT_CNT(REPEAT_CNT)) u_right (
    .clk_50m      (clk_50m),
    .rst_n        (rst_n),
    .flag_i       (key_bus.right_flag),
    .combo_rise_i (combo_rise_s),
    .press_o      (r_press_s),
    .release_o    (r_release_s),
    .long_o       (r_long_s),
    .rpt_o        (r_rpt_s)
  );

  assign key_bus.left_press    = l_press_s;
  assign key_bus.left_release  = l_release_s;
  assign key_bus.left_long     = l_long_s;
  assign key_bus.left_rpt      = l_rpt_s;
  assign key_bus.right_press   = r_press_s;
  assign key_bus.right_release = r_release_s;
  assign key_bus.right_long    = r_long_s;
  assign key_bus.right_rpt     = r_rpt_s;
  assign key_bus.both_press    = both_press_q;
endmodule

// File: doc/key_event_decoder.md
KEY_EVENT_DECODER -- requirements
Module: key_event_decoder

Interface
REQ-001 Parameter LONG_CNT, default 32'd50_000_000, sets the hold time in clk_50m cycles from press to long-press (1 s).
REQ-002 Parameter REPEAT_CNT, default 32'd10_000_000, sets the auto-repeat period in clk_50m cycles after long-press (200 ms).
REQ-003 clk_50m  input  1  system clock, 50 MHz; all logic on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 left_flag  input  1  debounced left key level, 1 = held, synchronous to clk_50m.
REQ-006 right_flag  input  1  debounced right key level, 1 = held, synchronous to clk_50m.
REQ-007 left_press / right_press  output  1 each  one-cycle pulse on key press.
REQ-008 left_release / right_release  output  1 each  one-cycle pulse on key release.
REQ-009 left_long / right_long  output  1 each  one-cycle pulse when hold reaches LONG_CNT.
REQ-010 left_rpt / right_rpt  output  1 each  one-cycle auto-repeat pulse while held past long-press.
REQ-011 both_press  output  1  one-cycle pulse when both keys become held together.

Function
REQ-012 All outputs SHALL be registered; each asserted pulse SHALL last exactly one clk_50m cycle.
REQ-013 Each key SHALL register its previous flag value; rise = flag & ~prev, fall = ~flag & prev.
REQ-014 Each key SHALL have an independent FSM with states IDLE, HELD, LONG, LOCK, and a 32-bit hold counter.
REQ-015 IDLE, rise: xxx_press SHALL assert one cycle after the first edge sampling flag = 1; FSM -> HELD; counter cleared to 0.
REQ-016 HELD, flag = 1: counter increments each cycle; when it reaches LONG_CNT-1, xxx_long SHALL pulse, counter SHALL clear, and FSM -> LONG.
REQ-017 LONG, flag = 1: counter increments; at REPEAT_CNT-1, xxx_rpt SHALL pulse and counter SHALL clear; repeats indefinitely every REPEAT_CNT cycles.
REQ-018 From HELD, LONG or LOCK, fall: xxx_release SHALL pulse; FSM -> IDLE; counter -> 0. No long/rpt pulse SHALL fire in that cycle.
REQ-019 Combo rise SHALL be (left_flag & right_flag) going from 0 to 1; both_press SHALL pulse once per combo rise; both FSMs SHALL enter LOCK.
REQ-020 LOCK SHALL hold the counter at 0 and suppress long and rpt pulses; exit is only via that key's fall (REQ-018).
REQ-021 LOCK SHALL persist after the other key releases; it is left only when this key itself releases.
REQ-022 Simultaneous rise of both keys in one cycle: left_press, right_press and both_press SHALL all pulse in the same cycle; both FSMs -> LOCK.
REQ-023 Second key pressed while first is in HELD or LONG: second key's press and both_press SHALL pulse together; both FSMs -> LOCK.
REQ-024 Counter SHALL never wrap; LONG_CNT >= 2 and REPEAT_CNT >= 2 are required. Other values are out of scope.
REQ-025 Long pulse and rpt pulse SHALL never coincide on the same key; the first rpt SHALL come REPEAT_CNT cycles after long.

Reset
REQ-026 On rst_n = 0, all outputs SHALL go to 0, FSMs to IDLE, counters to 0, and prev/combo registers to 0, immediately and asynchronously.
REQ-027 A key held across reset deassertion SHALL produce a press pulse one cycle after the first clock edge following release of reset.
REQ-028 Reset mid-hold SHALL produce no release pulse, and no pulse of any kind while rst_n = 0.

Verification (LONG_CNT=20, REPEAT_CNT=5)
REQ-029 left_flag 1 for 10 cycles, then 0 -> left_press once, left_release once 10 cycles later, no left_long.
REQ-030 left_flag held 40 cycles -> left_press; left_long 20 cycles after the press; left_rpt at +25, +30, +35 after press; left_release on fall.
REQ-031 right held 5 cycles, then left rises -> left_press and both_press in the same cycle; no long/rpt on either key until both release; two release pulses.
REQ-032 Both flags rise in the same cycle and are held 100 cycles -> left_press, right_press and both_press together; only release pulses follow.
REQ-033 Reset asserted 15 cycles into a left hold, released with the flag still 1 -> no release pulse; fresh left_press; left_long 20 cycles after it.
REQ-034 Flag toggles 1/0 every cycle for 10 cycles -> alternating press/release pulses on the matching key, no long, no rpt.
